// File: rtl/engine_pkg.sv
// Shared types and constants for the combat engine: FSM states, event codes,
// command codes, move directions and the saturating HP subtract.
package engine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_CMD   = 3'd1,
        ST_PLAYER_ACT = 3'd2,
        ST_RUN        = 3'd3,
        ST_ENEMY_ACT  = 3'd4,
        ST_DEAD       = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        EVT_HIT      = 3'd0,
        EVT_WIN      = 3'd1,
        EVT_LOSE     = 3'd2,
        EVT_RUN_OK   = 3'd3,
        EVT_RUN_FAIL = 3'd4,
        EVT_BAD_CMD  = 3'd5
    } evt_t;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_t;

    localparam logic [15:0] CMD_ATTACK = 16'd5;
    localparam logic [15:0] CMD_RUN    = 16'd6;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;

    // Subtract in 17 bits and clamp at zero so HP can never wrap.
    function automatic logic [15:0] sat_sub(input logic [15:0] a, input logic [16:0] b);
        logic [16:0] wide_a;
        wide_a = {1'b0, a};
        return (b >= wide_a) ? 16'd0 : a - b[15:0];
    endfunction

endpackage

// File: rtl/combat_controller_if.sv
// Command handshake plus event / escape-move outputs of the combat controller.
interface combat_controller_if;
    logic        cmd_valid;
    logic [15:0] cmd;
    logic        cmd_ready;
    logic        evt_valid;
    logic [2:0]  evt_code;
    logic        move_req;
    logic [1:0]  move_dir;

    modport master (
        output cmd_valid, cmd,
        input  cmd_ready, evt_valid, evt_code, move_req, move_dir
    );

    modport slave (
        input  cmd_valid, cmd,
        output cmd_ready, evt_valid, evt_code, move_req, move_dir
    );
endinterface

// File: rtl/rng_lfsr.sv
// Free-running 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1,
// seeded with 16'hACE1 on reset and stepped every clock.
module rng_lfsr
    import engine_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LFSR_SEED;
        else     state <= {state[0] ^ state[2] ^ state[3] ^ state[5], state[15:1]};
    end

endmodule

// File: rtl/combat_controller.sv
// Turn-based combat FSM with registered outputs. Define GODMODE_EN to make
// enemy strikes harmless (player HP frozen, always HIT, DEAD unreachable).
module combat_controller
    import engine_pkg::*;
#(
    parameter int PLAYER_MAX_HP = 100,
    parameter int ENEMY_HP      = 50,
    parameter int PLAYER_DMG    = 10,
    parameter int ENEMY_DMG     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enc_start,
    combat_controller_if.slave  bus,
    input  logic                rng_ovr,
    input  logic [3:0]          rng_ovr_val,
    output logic [15:0]         player_hp,
    output logic [15:0]         enemy_hp,
    output logic                in_combat
);

    state_t      state_q, state_d;
    logic [15:0] php_q, php_d;
    logic [15:0] ehp_q, ehp_d;
    logic        evt_valid_q, evt_valid_d;
    evt_t        evt_code_q, evt_code_d;
    logic        move_req_q, move_req_d;
    logic [1:0]  move_dir_q, move_dir_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        in_combat_q, in_combat_d;

    logic [15:0] lfsr_state;
    logic [3:0]  rnd;
    logic        unused_lfsr_hi;

    rng_lfsr u_rng (
        .clk   (clk),
        .rst   (rst),
        .state (lfsr_state)
    );

    assign rnd            = rng_ovr ? rng_ovr_val : lfsr_state[3:0];
    assign unused_lfsr_hi = ^lfsr_state[15:4];

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        php_d       = php_q;
        ehp_d       = ehp_q;
        evt_valid_d = 1'b0;
        evt_code_d  = evt_code_q;
        move_req_d  = 1'b0;
        move_dir_d  = move_dir_q;

        case (state_q)
            ST_IDLE: begin
                if (enc_start) begin
                    ehp_d   = 16'(ENEMY_HP);
                    state_d = ST_WAIT_CMD;
                end
            end
            ST_WAIT_CMD: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    if (bus.cmd == CMD_ATTACK)   state_d = ST_PLAYER_ACT;
                    else if (bus.cmd == CMD_RUN) state_d = ST_RUN;
                    else begin
                        evt_valid_d = 1'b1;
                        evt_code_d  = EVT_BAD_CMD;
                    end
                end
            end
            ST_PLAYER_ACT: begin
                ehp_d = sat_sub(ehp_q, 17'(PLAYER_DMG) + {15'd0, rnd[1:0]});
                if (ehp_d == 16'd0) begin
                    evt_valid_d = 1'b1;
                    evt_code_d  = EVT_WIN;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_ENEMY_ACT;
                end
            end
            ST_RUN: begin
                evt_valid_d = 1'b1;
                if (rnd[1:0] != 2'd0) begin
                    move_req_d = 1'b1;
                    move_dir_d = rnd[3:2];
                    evt_code_d = EVT_RUN_OK;
                    state_d    = ST_IDLE;
                end else begin
                    evt_code_d = EVT_RUN_FAIL;
                    state_d    = ST_ENEMY_ACT;
                end
            end
            ST_ENEMY_ACT: begin
                evt_valid_d = 1'b1;
`ifdef GODMODE_EN
                evt_code_d  = EVT_HIT;
                state_d     = ST_WAIT_CMD;
`else
                php_d = sat_sub(php_q, 17'(ENEMY_DMG));
                if (php_d == 16'd0) begin
                    evt_code_d = EVT_LOSE;
                    state_d    = ST_DEAD;
                end else begin
                    evt_code_d = EVT_HIT;
                    state_d    = ST_WAIT_CMD;
                end
`endif
            end
            ST_DEAD: state_d = ST_DEAD;
            default: state_d = ST_IDLE;
        endcase

        // Status flags follow the next state so they line up with it after the edge.
        cmd_ready_d = (state_d == ST_WAIT_CMD);
        in_combat_d = !(state_d inside {ST_IDLE, ST_DEAD});
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            php_q       <= 16'(PLAYER_MAX_HP);
            ehp_q       <= 16'd0;
            evt_valid_q <= 1'b0;
            evt_code_q  <= EVT_HIT;
            move_req_q  <= 1'b0;
            move_dir_q  <= 2'd0;
            cmd_ready_q <= 1'b0;
            in_combat_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            php_q       <= php_d;
            ehp_q       <= ehp_d;
            evt_valid_q <= evt_valid_d;
            evt_code_q  <= evt_code_d;
            move_req_q  <= move_req_d;
            move_dir_q  <= move_dir_d;
            cmd_ready_q <= cmd_ready_d;
            in_combat_q <= in_combat_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.evt_valid = evt_valid_q;
    assign bus.evt_code  = evt_code_q;
    assign bus.move_req  = move_req_q;
    assign bus.move_dir  = move_dir_q;
    assign player_hp     = php_q;
    assign enemy_hp      = ehp_q;
    assign in_combat     = in_combat_q;

endmodule

// File: tb/tb_combat_controller.sv
// Scoreboard bench for combat_controller: a turn-level reference model pushes
// expected events with their cycle; a negedge monitor pops and compares.
module tb_combat_controller;

    localparam int PMAX = 100;
    localparam int EHP  = 50;
    localparam int PDMG = 10;
    localparam int EDMG = 8;

    localparam int E_HIT = 0, E_WIN = 1, E_LOSE = 2, E_RUN_OK = 3, E_RUN_FAIL = 4, E_BAD = 5;
    localparam int M_IDLE = 0, M_FIGHT = 1, M_DEAD = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enc_start = 1'b0;
    logic        rng_ovr = 1'b0;
    logic [3:0]  rng_ovr_val = 4'd0;
    logic [15:0] player_hp, enemy_hp;
    logic        in_combat;

    combat_controller_if bus ();

    combat_controller #(
        .PLAYER_MAX_HP (PMAX),
        .ENEMY_HP      (EHP),
        .PLAYER_DMG    (PDMG),
        .ENEMY_DMG     (EDMG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enc_start   (enc_start),
        .bus         (bus),
        .rng_ovr     (rng_ovr),
        .rng_ovr_val (rng_ovr_val),
        .player_hp   (player_hp),
        .enemy_hp    (enemy_hp),
        .in_combat   (in_combat)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct {
        int at;
        int code;
        int php;
        int ehp;
        bit inc;
        bit rdy;
        bit mv;
        int dir;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int m_php  = PMAX;
    int m_ehp  = 0;
    int m_mode = M_IDLE;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference LFSR: value after n steps from the seed, right-shift Fibonacci form.
    function automatic int lfsr_after(input int n);
        int s, fb;
        s = 'hACE1;
        for (int i = 0; i < n; i++) begin
            fb = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
            s  = (s >> 1) | (fb << 15);
        end
        return s;
    endfunction

    task automatic push(input int at, input int code, input bit mv, input int dir);
        exp_t e;
        e.at   = at;
        e.code = code;
        e.php  = m_php;
        e.ehp  = m_ehp;
        e.inc  = (code == E_HIT) || (code == E_RUN_FAIL) || (code == E_BAD);
        e.rdy  = (code == E_HIT) || (code == E_BAD);
        e.mv   = mv;
        e.dir  = dir;
        sb.push_back(e);
    endtask

    task automatic enemy_strike(input int at);
`ifdef GODMODE_EN
        push(at, E_HIT, 0, 0);
`else
        m_php = (m_php > EDMG) ? m_php - EDMG : 0;
        if (m_php == 0) begin
            m_mode = M_DEAD;
            push(at, E_LOSE, 0, 0);
        end else begin
            push(at, E_HIT, 0, 0);
        end
`endif
    endtask

    // Monitor: flags stale expectations, then compares every presented event.
    always @(negedge clk) begin
        if (!rst) begin
            while (sb.size() > 0 && sb[0].at < cyc) begin
                mon_e = sb.pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL missed_evt: no event by cycle %0d, expected code %0d at %0d", cyc, mon_e.code, mon_e.at);
            end
            if (bus.evt_valid || bus.move_req) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_evt: code %0d move_req %0b at cycle %0d, none expected",
                             bus.evt_code, bus.move_req, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("evt_cycle", cyc, mon_e.at);
                    check("evt_valid", bus.evt_valid, 1);
                    check("evt_code", bus.evt_code, mon_e.code);
                    check("evt_player_hp", player_hp, mon_e.php);
                    check("evt_enemy_hp", enemy_hp, mon_e.ehp);
                    check("evt_in_combat", in_combat, mon_e.inc);
                    check("evt_cmd_ready", bus.cmd_ready, mon_e.rdy);
                    check("evt_move_req", bus.move_req, mon_e.mv);
                    if (mon_e.mv) check("evt_move_dir", bus.move_dir, mon_e.dir);
                end
            end
        end
    end

    task automatic do_reset();
        exp_t x;
        repeat (3) @(negedge clk);
        while (sb.size() > 0) begin
            x = sb.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL missed_evt: code %0d at cycle %0d never seen before reset", x.code, x.at);
        end
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        enc_start     = 1'b0;
        @(negedge clk);
        check("rst_player_hp", player_hp, PMAX);
        check("rst_enemy_hp", enemy_hp, 0);
        check("rst_in_combat", in_combat, 0);
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_evt_valid", bus.evt_valid, 0);
        check("rst_move_req", bus.move_req, 0);
        rst    = 1'b0;
        m_php  = PMAX;
        m_ehp  = 0;
        m_mode = M_IDLE;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.cmd_ready === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL cmd_ready_timeout: cmd_ready stayed 0 for 20 cycles, expected 1");
    endtask

    task automatic start_enc();
        @(negedge clk);
        enc_start = 1'b1;
        @(negedge clk);
        enc_start = 1'b0;
        if (m_mode == M_IDLE) begin
            m_mode = M_FIGHT;
            m_ehp  = EHP;
            check("enc_enemy_hp", enemy_hp, EHP);
            check("enc_in_combat", in_combat, 1);
            check("enc_cmd_ready", bus.cmd_ready, 1);
        end else if (m_mode == M_FIGHT) begin
            check("enc_ignored_ehp", enemy_hp, m_ehp);
        end else begin
            check("dead_in_combat", in_combat, 0);
            check("dead_cmd_ready", bus.cmd_ready, 0);
            check("dead_player_hp", player_hp, 0);
        end
    endtask

    task automatic issue_cmd(input logic [15:0] c, input logic ovr, input logic [3:0] val);
        int  n, r, dmg;
        bit  ok;
        wait_ready(ok);
        if (!ok) begin
            do_reset();
            return;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd       = c;
        rng_ovr       = ovr;
        rng_ovr_val   = val;
        n = cyc + 1;
        r = ovr ? int'(val) : (lfsr_after(n) & 15);
        if (c == 16'd5) begin
            dmg   = PDMG + (r % 4);
            m_ehp = (m_ehp > dmg) ? m_ehp - dmg : 0;
            if (m_ehp == 0) begin
                m_mode = M_IDLE;
                push(n + 1, E_WIN, 0, 0);
            end else begin
                enemy_strike(n + 2);
            end
        end else if (c == 16'd6) begin
            if ((r % 4) != 0) begin
                m_mode = M_IDLE;
                push(n + 1, E_RUN_OK, 1, r / 4);
            end else begin
                push(n + 1, E_RUN_FAIL, 0, 0);
                enemy_strike(n + 2);
            end
        end else begin
            push(n, E_BAD, 0, 0);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit          ok;
        int          pick;
        logic [15:0] c;

        bus.cmd_valid = 1'b0;
        bus.cmd       = 16'd0;
        do_reset();

        // Attack with r=0: enemy 50->40 one edge after accept, player hit one edge later.
        start_enc();
        issue_cmd(16'd5, 1'b1, 4'd0);
        @(negedge clk);
        check("lat_enemy_hp_n1", enemy_hp, 40);
        check("lat_player_hp_n1", player_hp, 100);

        issue_cmd(16'd3, 1'b1, 4'd0);
        issue_cmd(16'd6, 1'b1, 4'b1001);

        // Failed runs until the player dies (or, without damage, a fixed count).
        start_enc();
        for (int i = 0; i < 20 && m_mode == M_FIGHT; i++) issue_cmd(16'd6, 1'b1, 4'd0);
        repeat (4) @(negedge clk);
`ifdef GODMODE_EN
        check("god_player_hp", player_hp, PMAX);
`else
        start_enc();
`endif

        // Reset while the enemy strike is pending: encounter dropped silently.
        do_reset();
        start_enc();
        wait_ready(ok);
        if (ok) begin
            bus.cmd_valid = 1'b1;
            bus.cmd       = 16'd5;
            rng_ovr       = 1'b1;
            rng_ovr_val   = 4'd0;
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            @(posedge clk);
            #1;
            check("midrst_enemy_hp_pre", enemy_hp, 40);
            rst = 1'b1;
            #1;
            check("midrst_player_hp", player_hp, PMAX);
            check("midrst_evt_valid", bus.evt_valid, 0);
            check("midrst_in_combat", in_combat, 0);
            check("midrst_cmd_ready", bus.cmd_ready, 0);
            @(negedge clk);
            rst    = 1'b0;
            m_php  = PMAX;
            m_ehp  = 0;
            m_mode = M_IDLE;
        end

        // Randomized play, mixing LFSR-driven and overridden randomness.
        for (int it = 0; it < 150; it++) begin
            if (m_mode == M_IDLE) begin
                start_enc();
            end else if (m_mode == M_DEAD) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 7) == 0) start_enc();
                pick = $urandom_range(0, 19);
                if (pick < 9)       c = 16'd5;
                else if (pick < 17) c = 16'd6;
                else begin
                    c = 16'($urandom_range(0, 65535));
                    if (c == 16'd5 || c == 16'd6) c = 16'd7;
                end
                issue_cmd(c, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            end
        end

        repeat (6) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
